// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: control-word bit
// positions of the memory ops, FSM encoding and memory-op decode.
package mem_stage_pkg;

    // Control-word bit positions of the memory-op flags (same as the decoder).
    localparam int CTRL_MEM_RDB = 8;
    localparam int CTRL_MEM_RDW = 9;
    localparam int CTRL_MEM_WRB = 10;
    localparam int CTRL_MEM_WRW = 11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BEAT1 = 3'd1,
        ST_GAP   = 3'd2,
        ST_BEAT2 = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic is_mem;
        logic is_write;
        logic is_word;
    } mem_op_t;

    // Resolve the four op flags {wrw, wrb, rdw, rdb}: a write wins over a
    // read, and a word access wins over a byte access.
    function automatic mem_op_t decode_mem_op(input logic [3:0] bits);
        mem_op_t op;
        op = '0;
        if (bits[3] || bits[2]) begin
            op.is_mem   = 1'b1;
            op.is_write = 1'b1;
            op.is_word  = bits[3];
        end else if (bits[1] || bits[0]) begin
            op.is_mem   = 1'b1;
            op.is_write = 1'b0;
            op.is_word  = bits[1];
        end else begin
            op = '0;
        end
        return op;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for the 16-bit bus: byte enables and write-lane
// steering for the beat being issued, plus read-byte extraction for the
// beat currently on the bus.
module mem_lane_align (
    input  logic        addr0_i,   // bit 0 of the access start address
    input  logic        word_i,    // 1 = word access, 0 = byte access
    input  logic        beat_i,    // 0 = first beat, 1 = second beat of a split
    input  logic [15:0] wdata_i,   // unsteered store data
    input  logic        rd_odd_i,  // bit 0 of the address of the beat on the bus
    input  logic [15:0] rdata_i,   // raw bus read data
    output logic [1:0]  be_o,
    output logic [15:0] wdata_o,
    output logic [7:0]  rbyte_o
);

    // Byte enables and write-lane steering for the beat about to be issued.
    always_comb begin
        be_o    = 2'b00;
        wdata_o = 16'h0000;
        if (word_i && !addr0_i) begin
            be_o    = 2'b11;
            wdata_o = wdata_i;
        end else if (word_i && !beat_i) begin
            // Misaligned word, first beat: low byte goes to the odd lane.
            be_o    = 2'b10;
            wdata_o = {wdata_i[7:0], wdata_i[7:0]};
        end else if (word_i) begin
            // Misaligned word, second beat: high byte goes to the even lane.
            be_o    = 2'b01;
            wdata_o = {wdata_i[15:8], wdata_i[15:8]};
        end else begin
            be_o    = addr0_i ? 2'b10 : 2'b01;
            wdata_o = {wdata_i[7:0], wdata_i[7:0]};
        end
    end

    // Pick the byte lane addressed by the beat currently on the bus.
    always_comb begin
        rbyte_o = 8'h00;
        if (rd_odd_i) begin
            rbyte_o = rdata_i[15:8];
        end else begin
            rbyte_o = rdata_i[7:0];
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: accepts an instruction from alu_stage, runs up to two
// req/ack bus beats for loads/stores (misaligned words split in two), and
// presents control word, PC and result to writeback with a one-cycle ready.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int CTRL_W = 32,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [DATA_W-1:0] pc_in,
    output logic              ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] result_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e              state_q, state_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                is_write_q, is_write_d;
    logic                is_word_q, is_word_d;
    logic [7:0]          lo_q, lo_d;
    logic                ready_q, ready_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [1:0]          be_q, be_d;
    logic [DATA_W-1:0]   maddr_q, maddr_d;
    logic [DATA_W-1:0]   mwdata_q, mwdata_d;

    mem_op_t             dec_s;
    logic                accept_s;
    logic                ack_s;
    logic                split_s;
    logic [1:0]          be_s;
    logic [DATA_W-1:0]   wlane_s;
    logic [7:0]          rbyte_s;
    logic [DATA_W-1:0]   final_s;

    assign dec_s    = decode_mem_op({ctrl_in[CTRL_MEM_WRW], ctrl_in[CTRL_MEM_WRB],
                                     ctrl_in[CTRL_MEM_RDW], ctrl_in[CTRL_MEM_RDB]});
    assign accept_s = (state_q == ST_IDLE) && en;
    assign ack_s    = mem_ack && req_q;   // acks with no request outstanding are dropped
    assign split_s  = is_word_q && addr_q[0];

    // Load result assembled from the beat(s); non-loads return the address.
    assign final_s  = is_write_q ? addr_q :
                      (is_word_q ? (split_s ? {rbyte_s, lo_q} : mem_rdata)
                                 : {8'h00, rbyte_s});

    mem_lane_align u_lane_align (
        .addr0_i  (addr_d[0]),
        .word_i   (is_word_d),
        .beat_i   (state_d == ST_BEAT2),
        .wdata_i  (wdata_d),
        .rd_odd_i (maddr_q[0]),
        .rdata_i  (mem_rdata),
        .be_o     (be_s),
        .wdata_o  (wlane_s),
        .rbyte_o  (rbyte_s)
    );

    // Next-state logic: transfer sequencing, input latching, result capture.
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        pc_d       = pc_q;
        result_d   = result_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        is_word_d  = is_word_q;
        lo_d       = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    ctrl_d     = ctrl_in;
                    pc_d       = pc_in;
                    addr_d     = addr_in;
                    wdata_d    = wdata_in;
                    is_write_d = dec_s.is_write;
                    is_word_d  = dec_s.is_word;
                    if (dec_s.is_mem) begin
                        state_d = ST_BEAT1;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = addr_in;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BEAT1: begin
                if (ack_s && split_s) begin
                    state_d = ST_GAP;
                    lo_d    = rbyte_s;
                end else if (ack_s) begin
                    state_d  = ST_DONE;
                    result_d = final_s;
                end else begin
                    state_d = ST_BEAT1;
                end
            end
            ST_GAP: begin
                state_d = ST_BEAT2;
            end
            ST_BEAT2: begin
                if (ack_s) begin
                    state_d  = ST_DONE;
                    result_d = final_s;
                end else begin
                    state_d = ST_BEAT2;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus and handshake outputs for the coming cycle, so they leave flops.
    always_comb begin
        req_d    = (state_d == ST_BEAT1) || (state_d == ST_BEAT2);
        ready_d  = (state_d == ST_DONE);
        we_d     = req_d && is_write_d;
        be_d     = req_d ? be_s : 2'b00;
        mwdata_d = (req_d && is_write_d) ? wlane_s : 16'h0000;
        if (state_d == ST_BEAT1) begin
            maddr_d = addr_d;
        end else if (state_d == ST_BEAT2) begin
            maddr_d = addr_d + 16'd1;   // second beat wraps FFFF -> 0000
        end else begin
            maddr_d = 16'h0000;
        end
    end

    // State and output registers; reset drops any transfer in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            pc_q       <= '0;
            result_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            is_word_q  <= 1'b0;
            lo_q       <= 8'h00;
            ready_q    <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= 2'b00;
            maddr_q    <= '0;
            mwdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            result_q   <= result_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            is_word_q  <= is_word_d;
            lo_q       <= lo_d;
            ready_q    <= ready_d;
            req_q      <= req_d;
            we_q       <= we_d;
            be_q       <= be_d;
            maddr_q    <= maddr_d;
            mwdata_q   <= mwdata_d;
        end
    end

    assign ready      = ready_q;
    assign ctrl_out   = ctrl_q;
    assign pc_out     = pc_q;
    assign result_out = result_q;
    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_be     = be_q;
    assign mem_addr   = maddr_q;
    assign mem_wdata  = mwdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: pass-through, aligned and
// split accesses, wait states, reset mid-transfer and ignored en/ack.
module tb_mem_stage;

    localparam logic [31:0] C_ALU = 32'hFFFF_F0FF;   // no memory-op bits set
    localparam logic [31:0] C_RDB = 32'h0000_0100;
    localparam logic [31:0] C_RDW = 32'h0000_0200;
    localparam logic [31:0] C_WRB = 32'h0000_0400;
    localparam logic [31:0] C_WRW = 32'h0000_0800;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] ctrl_in;
    logic [15:0] addr_in, wdata_in, pc_in;
    logic        ready;
    logic [31:0] ctrl_out;
    logic [15:0] pc_out, result_out;
    logic        mem_req, mem_we;
    logic [1:0]  mem_be;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int ready_cnt = 0;

    mem_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .ctrl_in    (ctrl_in),
        .addr_in    (addr_in),
        .wdata_in   (wdata_in),
        .pc_in      (pc_in),
        .ready      (ready),
        .ctrl_out   (ctrl_out),
        .pc_out     (pc_out),
        .result_out (result_out),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Count ready pulses over the whole run.
    always @(negedge clk) begin
        if (ready === 1'b1) ready_cnt <= ready_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present one instruction for a single cycle; returns one cycle later.
    task automatic issue(input logic [31:0] c, input logic [15:0] a,
                         input logic [15:0] w, input logic [15:0] p);
        en       = 1'b1;
        ctrl_in  = c;
        addr_in  = a;
        wdata_in = w;
        pc_in    = p;
        tick();
        en = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        ctrl_in   = 32'h0;
        addr_in   = 16'h0;
        wdata_in  = 16'h0;
        pc_in     = 16'h0;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0;
        tick();
        tick();
        check("rst_ready",  {31'd0, ready},   32'd0);
        check("rst_req",    {31'd0, mem_req}, 32'd0);
        check("rst_ctrl",   ctrl_out,         32'd0);
        check("rst_result", {16'd0, result_out}, 32'd0);
        check("rst_addr",   {16'd0, mem_addr},   32'd0);
        rst_n = 1'b1;
        tick();

        // 1: ALU op passes straight through
        issue(C_ALU, 16'h1234, 16'h0000, 16'h0010);
        check("t1_ready",  {31'd0, ready},       32'd1);
        check("t1_result", {16'd0, result_out},  32'h0000_1234);
        check("t1_ctrl",   ctrl_out,             C_ALU);
        check("t1_pc",     {16'd0, pc_out},      32'h0000_0010);
        check("t1_req",    {31'd0, mem_req},     32'd0);
        tick();
        check("t1_ready_end", {31'd0, ready},    32'd0);
        check("t1_req_end",   {31'd0, mem_req},  32'd0);

        // 2: aligned word read, zero-wait ack
        issue(C_RDW, 16'h0100, 16'h0000, 16'h0020);
        check("t2_req",  {31'd0, mem_req},  32'd1);
        check("t2_we",   {31'd0, mem_we},   32'd0);
        check("t2_be",   {30'd0, mem_be},   32'd3);
        check("t2_addr", {16'd0, mem_addr}, 32'h0000_0100);
        check("t2_ready_early", {31'd0, ready}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        check("t2_ready",  {31'd0, ready},      32'd1);
        check("t2_result", {16'd0, result_out}, 32'h0000_BEEF);
        check("t2_req_off", {31'd0, mem_req},   32'd0);
        tick();

        // 3: odd byte read with three wait cycles
        issue(C_RDB, 16'h0101, 16'h0000, 16'h0030);
        for (int i = 0; i < 3; i++) begin
            check("t3_wait_req",  {31'd0, mem_req},  32'd1);
            check("t3_wait_addr", {16'd0, mem_addr}, 32'h0000_0101);
            check("t3_wait_be",   {30'd0, mem_be},   32'd2);
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 16'hA55A;
        tick();
        mem_ack = 1'b0;
        check("t3_ready",  {31'd0, ready},      32'd1);
        check("t3_result", {16'd0, result_out}, 32'h0000_00A5);
        tick();

        // 4: misaligned word write at FFFF, split with one-cycle gap
        issue(C_WRW, 16'hFFFF, 16'h1234, 16'h0040);
        check("t4_b1_req",  {31'd0, mem_req},  32'd1);
        check("t4_b1_we",   {31'd0, mem_we},   32'd1);
        check("t4_b1_addr", {16'd0, mem_addr}, 32'h0000_FFFF);
        check("t4_b1_be",   {30'd0, mem_be},   32'd2);
        check("t4_b1_data", {24'd0, mem_wdata[15:8]}, 32'h0000_0034);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t4_gap_req",   {31'd0, mem_req}, 32'd0);
        check("t4_gap_ready", {31'd0, ready},   32'd0);
        tick();
        check("t4_b2_req",  {31'd0, mem_req},  32'd1);
        check("t4_b2_we",   {31'd0, mem_we},   32'd1);
        check("t4_b2_addr", {16'd0, mem_addr}, 32'h0000_0000);
        check("t4_b2_be",   {30'd0, mem_be},   32'd1);
        check("t4_b2_data", {24'd0, mem_wdata[7:0]}, 32'h0000_0012);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t4_ready",  {31'd0, ready},      32'd1);
        check("t4_result", {16'd0, result_out}, 32'h0000_FFFF);
        tick();

        // 5: reset during a BEAT1 wait, then a fresh transfer
        issue(C_RDW, 16'h0200, 16'h0000, 16'h0050);
        check("t5_req", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_req",   {31'd0, mem_req}, 32'd0);
        check("t5_rst_ready", {31'd0, ready},   32'd0);
        check("t5_rst_ctrl",  ctrl_out,         32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        // write+read and byte+word flags together: aligned word write only
        issue(C_WRB | C_WRW | C_RDB, 16'h0300, 16'h5678, 16'h0060);
        check("t5_new_req",  {31'd0, mem_req},   32'd1);
        check("t5_new_we",   {31'd0, mem_we},    32'd1);
        check("t5_new_be",   {30'd0, mem_be},    32'd3);
        check("t5_new_addr", {16'd0, mem_addr},  32'h0000_0300);
        check("t5_new_data", {16'd0, mem_wdata}, 32'h0000_5678);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t5_ready",  {31'd0, ready},      32'd1);
        check("t5_result", {16'd0, result_out}, 32'h0000_0300);
        check("t5_pc",     {16'd0, pc_out},     32'h0000_0060);
        tick();

        // 6: en while busy and ack without req are ignored
        issue(C_RDW, 16'h0400, 16'h0000, 16'h0070);
        en = 1'b1; ctrl_in = C_ALU; addr_in = 16'h5555;
        tick();
        en = 1'b0;
        check("t6_busy_req",  {31'd0, mem_req},  32'd1);
        check("t6_busy_addr", {16'd0, mem_addr}, 32'h0000_0400);
        check("t6_busy_ctrl", ctrl_out,          C_RDW);
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        tick();
        mem_ack = 1'b0;
        check("t6_ready",  {31'd0, ready},      32'd1);
        check("t6_result", {16'd0, result_out}, 32'h0000_1111);
        en = 1'b1; ctrl_in = C_ALU; addr_in = 16'h7777;
        tick();
        en = 1'b0;
        check("t6_done_en_ready",  {31'd0, ready},      32'd0);
        check("t6_done_en_result", {16'd0, result_out}, 32'h0000_1111);
        check("t6_done_en_ctrl",   ctrl_out,            C_RDW);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t6_stray_ack_ready", {31'd0, ready},   32'd0);
        check("t6_stray_ack_req",   {31'd0, mem_req}, 32'd0);
        tick();
        check("ready_pulses", ready_cnt, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
